// File: rtl/mips_core_pkg.sv
// Shared core types: fetch queue entry layout and default sizing.
package mips_core_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned FETCH_QUEUE_DEPTH_LOG2_DEFAULT = 2;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Register array for the fetch queue: one synchronous write port, one asynchronous read port.
module fetch_queue_storage
   import mips_core_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = FETCH_QUEUE_DEPTH_LOG2_DEFAULT
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  fetch_entry_t          wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output fetch_entry_t          rdata
);

   fetch_entry_t mem_q [2**DEPTH_LOG2];

   // Contents are intentionally not reset; pointers and count gate visibility.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Cache-to-decode fetch FIFO with single-cycle flush.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import mips_core_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = FETCH_QUEUE_DEPTH_LOG2_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   input  logic [DATA_WIDTH-1:0] i_instr,
   output logic                  o_ready,
   input  logic                  i_flush,
   output logic                  o_valid,
   output logic [ADDR_WIDTH-1:0] o_pc,
   output logic [DATA_WIDTH-1:0] o_instr,
   input  logic                  i_ready,
   output logic [DEPTH_LOG2:0]   o_count
);

   localparam int unsigned Depth = 2**DEPTH_LOG2;

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;

   logic         empty;
   logic         bypass;
   logic         wr_en;
   logic         rd_en;
   fetch_entry_t in_entry;
   fetch_entry_t rd_entry;
   fetch_entry_t head;

   assign empty    = (count_q == '0);
   assign o_ready  = (count_q != (DEPTH_LOG2+1)'(Depth));
   assign o_count  = count_q;
   assign in_entry = '{pc: i_pc, instr: i_instr};

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = empty & i_valid;
`else
   assign bypass = 1'b0;
`endif

   assign o_valid = ~i_flush & (~empty | bypass);
   // A bypassed entry consumed in the same cycle never touches storage or the count.
   assign wr_en   = i_valid & o_ready & ~i_flush & ~(bypass & i_ready);
   assign rd_en   = o_valid & i_ready & ~bypass;

   assign head    = bypass ? in_entry : rd_entry;
   assign o_pc    = o_valid ? head.pc : '0;
   assign o_instr = o_valid ? head.instr : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      count_d = count_q + {{DEPTH_LOG2{1'b0}}, wr_en} - {{DEPTH_LOG2{1'b0}}, rd_en};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fetch_queue_storage #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_storage (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (in_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between the instruction cache and decode. Captures each valid cache hit (PC plus 32-bit instruction word) and presents entries in order to decode over a valid/ready handshake, so decode stalls do not force the cache to hold its output. A single-cycle flush discards all buffered instructions on branch redirect or exception.

## Interface
- `DEPTH_LOG2`, default 2: queue holds 2^DEPTH_LOG2 entries; legal range 1..4.
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `i_valid`  in  1  the cache presents a hit this cycle.
- `i_pc`  in  `ADDR_WIDTH`  byte PC of the incoming instruction.
- `i_instr`  in  `DATA_WIDTH`  instruction word from the cache.
- `o_ready`  out  1  queue accepts an enqueue this cycle.
- `i_flush`  in  1  discard all entries; has priority over everything except reset.
- `o_valid`  out  1  head entry is presented to decode.
- `o_pc`  out  `ADDR_WIDTH`  PC of the head entry.
- `o_instr`  out  `DATA_WIDTH`  instruction word of the head entry.
- `i_ready`  in  1  decode consumes the head this cycle.
- `o_count`  out  DEPTH_LOG2+1  number of occupied entries.

## Operation
- Enqueue fires when `i_valid & o_ready & ~i_flush`. Dequeue fires when `o_valid & i_ready & ~i_flush`.
- `o_ready = (count != 2^DEPTH_LOG2)`. It depends only on registered state and never on `i_ready`, so there is no combinational path from decode to the cache.
- A full queue with a dequeue in the same cycle still reports `o_ready=0`.
- Storage is circular. `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits wide and wrap modulo the depth. Count is tracked separately as `count_next = count + enq - deq`.
- Simultaneous enqueue and dequeue at count=1..DEPTH-1: count is unchanged and both pointers advance.
- Flush: `count`, `wr_ptr` and `rd_ptr` go to 0 at the next edge. Any same-cycle enqueue is dropped. `o_valid` is forced to 0 combinationally during the flush cycle.
- When `o_valid=0`, `o_pc` and `o_instr` are driven to 0.
- There is no error on overflow or underflow; the handshake rules make both impossible.

## Timing
- Reset state: `count=0`, pointers 0, `o_valid=0`, `o_pc=0`, `o_instr=0`, `o_count=0`, `o_ready=1`.
- Without bypass, the minimum latency is 1 cycle: an entry enqueued at edge N appears on `o_valid` in cycle N+1.
- Sustained throughput is 1 instruction per cycle when decode is always ready and count is at least 1.
- Reset asserted mid-operation overrides flush and all traffic; the state above is reached on the same edge.
- Storage contents are not reset. Only pointers and count are reset.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When count=0 and `i_valid` and no flush, the incoming entry drives `o_valid`, `o_pc` and `o_instr` combinationally in the same cycle.
  - If `i_ready` is also 1 in that cycle, the entry is consumed without being written, and pointers and count stay unchanged.
  - If `i_ready` is 0, the entry is written normally.
- Not defined:
  - No bypass path exists.
  - `o_*` depend on registered state only, except for the flush gating.

## Structure
- Shared package `mips_core_pkg`:
  - `fetch_entry_t`, a packed struct of {pc `ADDR_WIDTH`, instr `DATA_WIDTH`}.
  - `FETCH_QUEUE_DEPTH_LOG2_DEFAULT`.
- Sub-module `fetch_queue_storage`: a 2^DEPTH_LOG2 × `fetch_entry_t` register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- `fetch_queue` holds pointers, count, handshake logic and the bypass mux.

## Test plan
- **Reset, then fill:** reset; `i_valid=1` with PCs 0x00, 0x04, 0x08, 0x0C and `i_ready=0` → `o_count` reaches 4 and `o_ready=0` after the 4th edge; `o_pc=0x00` throughout.
- **Drain and wrap:** fill to 4, then `i_ready=1` for 6 cycles while enqueuing 0x10 and 0x14 → outputs appear in order 0x00…0x14, pointers wrap, and count ends at 0.
- **Simultaneous enqueue/dequeue:** count=2 with `i_valid=i_ready=1` for 10 cycles → count stays 2 and the order is preserved.
- **Flush:**
  - Count=3 with `i_flush=1` and `i_valid=1` → `o_valid=0` in that cycle; count=0 next cycle; the flushed-cycle PC never appears.
  - The next enqueue, PC 0x40, is the first output.
- **Reset mid-stream:** count=2 with `rst_n=0` for one edge alongside enqueue → count=0, `o_valid=0`, `o_pc=0`.
- **Bypass:**
  - With `FETCH_QUEUE_BYPASS_EN`: empty, `i_valid=i_ready=1`, PC 0x80 → `o_valid=1` and `o_pc=0x80` in the same cycle, and count stays 0.
  - Without it: `o_valid` rises the next cycle.
